// File: rtl/rv32imac_pkg.sv
// Shared types and constants for the rv32imac data-memory responder.
package rv32imac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
  localparam int unsigned DMEM_CNT_W    = 2;

endpackage

// File: rtl/rv32imac_sram_be.sv
// Single-port word array with synchronous read and per-byte write enables.
module rv32imac_sram_be #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write, or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/rv32imac_dmem_resp.sv
// Fixed-latency data-memory responder with out-of-range error and tohost MMIO.
module rv32imac_dmem_resp
  import rv32imac_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  input  logic        dmem_req,
  input  logic        dmem_we,
  output logic [31:0] dmem_rdata,
  output logic        dmem_valid,
  output logic        dmem_err,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
  localparam bit          LAT_ONE = (LATENCY == 1);

  if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
    $error("rv32imac_dmem_resp: LATENCY must be in 1..4");
  end

  dmem_state_e           state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;

  logic [31:0] cur_addr, cur_wdata, cur_off, sram_rdata;
  logic [3:0]  cur_be;
  logic        cur_we, cur_in_range, cur_tohost, go;
  logic        unused_off;

  // Select live inputs in IDLE (LATENCY=1 path) or the captured request otherwise.
  always_comb begin
    cur_addr     = (state == IDLE) ? dmem_addr  : addr_q;
    cur_wdata    = (state == IDLE) ? dmem_wdata : wdata_q;
    cur_be       = (state == IDLE) ? dmem_be    : be_q;
    cur_we       = (state == IDLE) ? dmem_we    : we_q;
    cur_off      = cur_addr - BASE_ADDR;
    cur_in_range = (cur_off < SPAN);
    cur_tohost   = (cur_addr[31:2] == TOHOST_ADDR[31:2]);
    go           = !rst && (((state == IDLE) && dmem_req && LAT_ONE) ||
                            ((state == WAIT) && (cnt == '0)));
  end

  assign unused_off = ^{cur_off[31:AW+2], cur_off[1:0]};

  // The array is touched only on the edge that enters RESP.
  rv32imac_sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .en    (go && cur_in_range),
    .we    (cur_we),
    .be    (cur_be),
    .addr  (cur_off[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (sram_rdata)
  );

  // Response word: SRAM data for loads, error pattern on a miss, zero otherwise.
  assign dmem_rdata = !dmem_valid ? 32'h0 :
                      dmem_err    ? DMEM_ERR_DATA :
                      we_q        ? 32'h0 : sram_rdata;

  // Request FSM, completion flags and tohost register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      dmem_valid   <= 1'b0;
      dmem_err     <= 1'b0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      dmem_valid <= 1'b0;
      dmem_err   <= 1'b0;
      if (go) begin
        dmem_valid <= 1'b1;
        dmem_err   <= !cur_in_range;
        if (cur_we && cur_tohost) begin
          tohost_valid <= 1'b1;
          tohost_data  <= cur_wdata;
        end
      end
      case (state)
        IDLE: begin
          if (dmem_req) begin
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wdata;
            be_q    <= dmem_be;
            we_q    <= dmem_we;
            state   <= LAT_ONE ? RESP : WAIT;
            cnt     <= LAT_ONE ? '0 : DMEM_CNT_W'(LATENCY - 2);
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32imac_dmem_resp.sv
// Randomized self-checking bench: three responders (LATENCY 1, 3, 4) against a word-map model.
module tb_rv32imac_dmem_resp;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;

  logic        clk;
  logic [2:0]  rst, req;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata [3];
  logic [31:0] tdata [3];
  logic [2:0]  valid, err, tv;

  int unsigned lat [3] = '{1, 3, 4};
  int n_cmp = 0;
  int n_bad = 0;

  bit [31:0] mm [longint];
  bit        tv_m [3];
  bit [31:0] td_m [3];

  rv32imac_dmem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_be(be),
    .dmem_req(req[0]), .dmem_we(we), .dmem_rdata(rdata[0]), .dmem_valid(valid[0]),
    .dmem_err(err[0]), .tohost_valid(tv[0]), .tohost_data(tdata[0]));

  rv32imac_dmem_resp #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_be(be),
    .dmem_req(req[1]), .dmem_we(we), .dmem_rdata(rdata[1]), .dmem_valid(valid[1]),
    .dmem_err(err[1]), .tohost_valid(tv[1]), .tohost_data(tdata[1]));

  rv32imac_dmem_resp #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[2]), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_be(be),
    .dmem_req(req[2]), .dmem_we(we), .dmem_rdata(rdata[2]), .dmem_valid(valid[2]),
    .dmem_err(err[2]), .tohost_valid(tv[2]), .tohost_data(tdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h4000);
  endfunction

  function automatic longint key(input int k, input logic [31:0] a);
    return (longint'(k) <<< 32) | longint'(a[31:2]);
  endfunction

  // One handshake: raise req in IDLE, time the valid pulse, drop req, check idle outputs.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output logic [31:0] rd, output logic er);
    int  n;
    bit  got;
    addr = a; wdata = wd; be = b; we = w; req[k] = 1'b1;
    n = 0; got = 0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (valid[k]) got = 1;
    end
    if (!got) check("valid_timeout", 32'd0, 32'd1);
    else      check("latency", 32'(n), 32'(lat[k]));
    rd = rdata[k];
    er = err[k];
    req[k] = 1'b0;
    @(posedge clk); #1;
    check("pulse_width", 32'(valid[k]), 32'd0);
    check("idle_rdata", rdata[k], 32'd0);
    check("idle_err", 32'(err[k]), 32'd0);
  endtask

  // Access plus comparison against and update of the reference model.
  task automatic op(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] b);
    logic [31:0] rd, cur;
    logic        er;
    bit          exp_err;
    access(k, w, a, wd, b, rd, er);
    exp_err = !in_rng(a);
    check("err", 32'(er), 32'(exp_err));
    if (!w) begin
      if (exp_err)                 check("rdata_oor", rd, DEAD);
      else if (mm.exists(key(k, a))) check("rdata", rd, mm[key(k, a)]);
    end else begin
      if (!exp_err) begin
        cur = mm.exists(key(k, a)) ? mm[key(k, a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
        mm[key(k, a)] = cur;
      end
      if (a[31:2] == TOHOST[31:2]) begin
        tv_m[k] = 1'b1;
        td_m[k] = wd;
      end
    end
    check("tohost_valid", 32'(tv[k]), 32'(tv_m[k]));
    check("tohost_data", tdata[k], td_m[k]);
  endtask

  task automatic do_rst(input int k);
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    tv_m[k] = 1'b0;
    td_m[k] = 32'h0;
  endtask

  logic [31:0] oor [4] = '{32'h0000_0100, 32'h7FFF_FFFC, 32'h8000_4000, 32'hFFFF_FFFC};

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          n, pick;
    bit          seen;

    rst = 3'b111; req = 3'b000; addr = '0; wdata = '0; be = '0; we = 1'b0;
    for (int k = 0; k < 3; k++) begin tv_m[k] = 0; td_m[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_valid", 32'(valid[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_rdata", rdata[k], 32'd0);
      check("rst_tohost_valid", 32'(tv[k]), 32'd0);
      check("rst_tohost_data", tdata[k], 32'd0);
    end
    rst = 3'b000;
    @(posedge clk); #1;

    // Store then load, full word.
    op(0, 1, 32'h8000_0010, 32'h1234_5678, 4'b1111);
    access(0, 0, 32'h8000_0010, 32'h0, 4'b0000, rd, er);
    check("vec_store_load", rd, 32'h1234_5678);

    // Single-lane store over a known word.
    op(0, 1, 32'h8000_0014, 32'h1111_1111, 4'b1111);
    op(0, 1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0100);
    access(0, 0, 32'h8000_0014, 32'h0, 4'b0000, rd, er);
    check("vec_lane2", rd, 32'h11BB_1111);

    // Empty byte mask still completes and leaves data intact.
    op(0, 1, 32'h8000_0014, 32'hFFFF_FFFF, 4'b0000);
    op(0, 0, 32'h8000_0014, 32'h0, 4'b0000);

    // Out-of-range load and store.
    op(0, 0, 32'h0000_0100, 32'h0, 4'b0000);
    op(0, 1, 32'h0000_0100, 32'h5555_5555, 4'b1111);
    op(0, 0, 32'h0000_0100, 32'h0, 4'b0000);

    // tohost is sticky until reset.
    op(0, 1, TOHOST, 32'h0000_0001, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    check("tohost_hold_valid", 32'(tv[0]), 32'd1);
    check("tohost_hold_data", tdata[0], 32'd1);
    do_rst(0);
    check("tohost_cleared", 32'(tv[0]), 32'd0);
    check("tohost_data_cleared", tdata[0], 32'd0);
    op(0, 0, TOHOST, 32'h0, 4'b0000);

    // LATENCY=3 load at the base address.
    op(1, 1, BASE, 32'hA5A5_0F0F, 4'b1111);
    op(1, 0, BASE, 32'h0, 4'b0000);

    // Back-to-back: holding req gives one access every LATENCY+1 cycles.
    addr = BASE; we = 1'b0; be = 4'b0000; req[1] = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 12) begin @(posedge clk); #1; n++; seen = valid[1]; end
    check("b2b_first", 32'(n), 32'd3);
    n = 0; seen = 0;
    while (!seen && n < 12) begin @(posedge clk); #1; n++; seen = valid[1]; end
    check("b2b_period", 32'(n), 32'd4);
    check("b2b_rdata", rdata[1], 32'hA5A5_0F0F);
    req[1] = 1'b0;
    @(posedge clk); #1;

    // Reset during WAIT aborts a LATENCY=4 store.
    op(2, 1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111);
    addr = 32'h8000_0020; wdata = 32'h0BAD_0BAD; be = 4'b1111; we = 1'b1; req[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[2] = 1'b1; req[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    tv_m[2] = 0; td_m[2] = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (valid[2]) seen = 1; end
    check("abort_no_valid", 32'(seen), 32'd0);
    op(2, 0, 32'h8000_0020, 32'h0, 4'b0000);

    // Random traffic over a small word pool, tohost and out-of-range addresses.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) op(k, 1, BASE + 32'(4 * i), $urandom, 4'b1111);
      op(k, 1, TOHOST, $urandom, 4'b1111);
      for (int j = 0; j < 30; j++) begin
        pick = $urandom_range(0, 11);
        if (pick < 8)       a = BASE + 32'(4 * pick);
        else if (pick == 8) a = TOHOST;
        else                a = oor[pick - 8];
        a[1:0] = 2'($urandom_range(0, 3));
        op(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
